score_counter: RTL and testbench

Score register and display driver for one player, directly downstream of `pushbutton_processor`. It consumes the `count_up` / `count_down` events (short press / long press), keeps a saturating two-digit BCD score, and drives a two-digit multiplexed 7-segment display. It runs on the same 1 kHz system clock as the button processor.

---
 rtl/score_counter.sv | 86 ++++++++
 tb/tb_score_counter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/score_counter.sv
// score_counter: saturating two-digit BCD score with edge-detected up/down events and a multiplexed 7-segment display.
module score_counter #(
  parameter int MAX_SCORE   = 99,
  parameter int REFRESH_DIV = 5,
  parameter int BLANK_LZ    = 1
) (
  input  logic       clk_1khz,
  input  logic       rst_i,
  input  logic       count_up_i,
  input  logic       count_down_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       max_o,
  output logic       changed_o,
  output logic [6:0] seg_o,
  output logic [1:0] digit_sel_o
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [3:0] MAX_T = 4'(MAX_SCORE / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_SCORE % 10);
  logic up_q, dn_q, changed_q, changed_d;
  logic [3:0] tens_q, tens_d, ones_q, ones_d, dig;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [6:0] seg;
  logic up_ev, dn_ev, at_max, at_zero, inc, dec, wrap;
  always_comb begin
    up_ev     = count_up_i & ~up_q;
    dn_ev     = count_down_i & ~dn_q;
    at_max    = tens_q == MAX_T && ones_q == MAX_O;
    at_zero   = tens_q == 4'd0 && ones_q == 4'd0;
    inc       = up_ev & ~dn_ev & ~at_max;
    dec       = dn_ev & ~up_ev & ~at_zero;
    ones_d    = inc ? (ones_q == 4'd9 ? 4'd0 : ones_q + 4'd1)
              : dec ? (ones_q == 4'd0 ? 4'd9 : ones_q - 4'd1) : ones_q;
    tens_d    = inc && ones_q == 4'd9 ? tens_q + 4'd1
              : dec && ones_q == 4'd0 ? tens_q - 4'd1 : tens_q;
    changed_d = inc | dec;
    wrap      = cnt_q == LAST;
    cnt_d     = wrap ? '0 : cnt_q + CW'(1);
    sel_d     = wrap ? {sel_q[0], sel_q[1]} : sel_q;
    dig       = sel_q[1] ? tens_q : ones_q;
  end
  always_comb begin
    seg = 7'b0000000;
    case (dig)
      4'd0: seg = 7'b0111111;
      4'd1: seg = 7'b0000110;
      4'd2: seg = 7'b1011011;
      4'd3: seg = 7'b1001111;
      4'd4: seg = 7'b1100110;
      4'd5: seg = 7'b1101101;
      4'd6: seg = 7'b1111101;
      4'd7: seg = 7'b0000111;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
  end
  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
      sel_q     <= 2'b01;
    end else begin
      up_q      <= count_up_i;
      dn_q      <= count_down_i;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
    end
  end
  assign tens_o      = tens_q;
  assign ones_o      = ones_q;
  assign max_o       = at_max;
  assign changed_o   = changed_q;
  assign digit_sel_o = sel_q;
  assign seg_o       = (sel_q[1] && tens_q == 4'd0 && BLANK_LZ != 0) ? 7'b0000000 : seg;
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: drives a default and a MAX_SCORE=12 instance with shared stimulus and checks both against an integer score model.
module tb_score_counter;
  localparam int RD = 5;
  logic clk = 1'b0;
  logic rst = 1'b1, up = 1'b0, dn = 1'b0;
  logic [3:0] tens [2];
  logic [3:0] ones [2];
  logic       mx [2];
  logic       chg [2];
  logic [6:0] seg [2];
  logic [1:0] dsel [2];
  int errors = 0, checks = 0;
  int msc [2] = '{0, 0};
  bit mch [2] = '{0, 0};
  int maxv [2] = '{99, 12};
  bit pu = 0, pd = 0, valid = 0;
  int cyc = 0;
  bit [6:0] segt [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                          7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  always #5 clk = ~clk;

  score_counter dut (.clk_1khz(clk), .rst_i(rst), .count_up_i(up), .count_down_i(dn),
    .tens_o(tens[0]), .ones_o(ones[0]), .max_o(mx[0]), .changed_o(chg[0]),
    .seg_o(seg[0]), .digit_sel_o(dsel[0]));
  score_counter #(.MAX_SCORE(12)) dut12 (.clk_1khz(clk), .rst_i(rst), .count_up_i(up),
    .count_down_i(dn), .tens_o(tens[1]), .ones_o(ones[1]), .max_o(mx[1]),
    .changed_o(chg[1]), .seg_o(seg[1]), .digit_sel_o(dsel[1]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      msc = '{0, 0};
      mch = '{0, 0};
      pu = 0;
      pd = 0;
      cyc = 0;
      valid = 1;
    end else begin
      bit ue, de;
      ue = up && !pu;
      de = dn && !pd;
      for (int k = 0; k < 2; k++) begin
        int n;
        n = msc[k];
        if (ue && !de && n < maxv[k]) n++;
        if (de && !ue && n > 0) n--;
        mch[k] = n != msc[k];
        msc[k] = n;
      end
      pu = up;
      pd = dn;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      for (int k = 0; k < 2; k++) begin
        bit tsel;
        int d;
        tsel = ((cyc / RD) % 2) == 1;
        d = tsel ? msc[k] / 10 : msc[k] % 10;
        chk($sformatf("tens%0d", k), int'(tens[k]), msc[k] / 10);
        chk($sformatf("ones%0d", k), int'(ones[k]), msc[k] % 10);
        chk($sformatf("max%0d", k), int'(mx[k]), int'(msc[k] == maxv[k]));
        chk($sformatf("changed%0d", k), int'(chg[k]), int'(mch[k]));
        chk($sformatf("digit_sel%0d", k), int'(dsel[k]), tsel ? 2 : 1);
        chk($sformatf("seg%0d", k), int'(seg[k]), (tsel && msc[k] / 10 == 0) ? 0 : int'(segt[d]));
      end
    end
  end

  task automatic step(input bit u, input bit d, input bit r);
    up = u;
    dn = d;
    rst = r;
    @(posedge clk);
    #2;
  endtask

  task automatic pulses(input bit u, input int n);
    for (int i = 0; i < n; i++) begin
      step(u, !u, 0);
      step(0, 0, 0);
    end
  endtask

  initial begin
    #2;
    step(0, 0, 1);
    step(1, 0, 0);
    chk("t1_ones", int'(ones[0]), 1);
    chk("t1_changed", int'(chg[0]), 1);
    chk("t1_seg", int'(seg[0]), 7'b0000110);
    step(0, 0, 0);
    chk("t1_changed_drop", int'(chg[0]), 0);

    step(0, 0, 1);
    for (int i = 0; i < 30; i++) step(1, 0, 0);
    step(0, 0, 0);
    chk("t2_hold_once", int'(ones[0]), 1);
    pulses(1, 10);
    chk("t2_score11", int'({tens[0], ones[0]}), 8'h11);

    step(0, 0, 1);
    step(0, 1, 0);
    chk("t3_floor", int'({tens[0], ones[0]}), 0);
    chk("t3_floor_chg", int'(chg[0]), 0);
    step(0, 0, 0);
    pulses(1, 15);
    chk("t3_sat12", int'({tens[1], ones[1]}), 8'h12);
    chk("t3_max12", int'(mx[1]), 1);
    chk("t3_score15", int'({tens[0], ones[0]}), 8'h15);

    step(0, 0, 1);
    pulses(1, 10);
    pulses(0, 1);
    chk("t4_borrow", int'({tens[0], ones[0]}), 8'h09);
    step(1, 1, 0);
    chk("t4_both_chg", int'(chg[0]), 0);
    step(0, 0, 0);
    chk("t4_both_score", int'({tens[0], ones[0]}), 8'h09);

    step(0, 0, 1);
    pulses(1, 5);
    for (int i = 0; i < 20 && dsel[0] != 2'b10; i++) step(0, 0, 0);
    chk("t5_sel_tens", int'(dsel[0]), 2);
    chk("t5_blank", int'(seg[0]), 0);
    for (int i = 0; i < 20 && dsel[0] != 2'b01; i++) step(0, 0, 0);
    chk("t5_sel_ones", int'(dsel[0]), 1);
    chk("t5_seg5", int'(seg[0]), 7'b1101101);

    step(0, 0, 1);
    pulses(1, 37);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t6_score37", int'({tens[0], ones[0]}), 8'h37);
    step(1, 0, 1);
    chk("t6_rst_score", int'({tens[0], ones[0]}), 0);
    chk("t6_rst_sel", int'(dsel[0]), 1);
    step(0, 0, 0);
    chk("t6_up_ignored", int'({tens[0], ones[0]}), 0);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 79) == 0);
    step(0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
